// File: rtl/ntt_pkg.sv
// Shared definitions for the Kyber NTT core: sizes, butterfly mode codes,
// sequencer states and the write-back delay-line entry.
package ntt_pkg;

  localparam int N       = 256;
  localparam int LOGN    = 8;
  localparam int NLAYERS = 7;

  localparam logic [1:0] BF_NTT  = 2'b00;
  localparam logic [1:0] BF_INTT = 2'b01;
  localparam logic [1:0] BF_BYP  = 2'b10;
  localparam logic [1:0] BF_IDLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
  } wb_t;

endpackage

// File: rtl/ntt_ctrl_if.sv
// Control/address bundle between the NTT sequencer and the host/datapath.
interface ntt_ctrl_if;
  import ntt_pkg::*;

  logic            start;
  logic            inv;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [LOGN-2:0] tw_addr;
  logic [1:0]      bf_mode;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;

  modport master (
    output start, inv,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_mode,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start, inv,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_mode,
           wr_en, wr_addr_a, wr_addr_b
  );

endinterface

// File: rtl/ntt_addr_gen.sv
// Combinational (layer, butterfly, direction) -> (a, b, twiddle) mapping.
// All multiplies by powers of two are done as shifts on 8-bit quantities.
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic [2:0]      layer,
  input  logic [6:0]      bfly,
  input  logic            inv,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [6:0]      tw
);

  logic [3:0] layer_wide;
  logic [6:0] grp;
  logic [6:0] mask;
  logic [7:0] span;

  assign layer_wide = {1'b0, layer};

  always_comb begin
    span   = '0;
    grp    = '0;
    mask   = '0;
    addr_a = '0;
    tw     = '0;
    if (!inv) begin
      // Cooley-Tukey: len = 128>>l, group stride 2*len = 256>>l
      span   = 8'd128 >> layer;
      grp    = bfly >> (3'd7 - layer);
      mask   = 7'h7f >> layer;
      addr_a = ({1'b0, grp} << (4'd8 - layer_wide)) + {1'b0, bfly & mask};
      tw     = (7'd1 << layer) + grp;
    end else begin
      // Gentleman-Sande: len = 2<<l, group stride 2*len = 4<<l
      span   = 8'd2 << layer;
      grp    = bfly >> (layer_wide + 4'd1);
      mask   = ~(7'h7f << (layer_wide + 4'd1));
      addr_a = ({1'b0, grp} << (layer_wide + 4'd2)) + {1'b0, bfly & mask};
      tw     = (7'h7f >> layer) - grp;
    end
  end

  assign addr_b = addr_a + span;

endmodule

// File: rtl/ntt_ctrl.sv
// Layer/butterfly sequencer for the shared NTT butterfly: issues reads and
// twiddle indices, delays write-back addresses by WB_LAT, drains between layers.
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int WB_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  ntt_ctrl_if.slave   bus
);

  state_t     state_reg, state_next;
  logic [2:0] layer_reg, layer_next;
  logic [6:0] bfly_reg, bfly_next;
  logic [3:0] drain_reg, drain_next;
  logic       inv_reg, inv_next;

  logic [LOGN-1:0] gen_a, gen_b;
  logic [6:0]      gen_tw;
  logic            rd_en;

  wb_t wb_line [WB_LAT];

  ntt_addr_gen u_addr_gen (
    .layer  (layer_reg),
    .bfly   (bfly_reg),
    .inv    (inv_reg),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw     (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      layer_reg <= '0;
      bfly_reg  <= '0;
      drain_reg <= '0;
      inv_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      layer_reg <= layer_next;
      bfly_reg  <= bfly_next;
      drain_reg <= drain_next;
      inv_reg   <= inv_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    layer_next = layer_reg;
    bfly_next  = bfly_reg;
    drain_next = drain_reg;
    inv_next   = inv_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          inv_next   = bus.inv;
          layer_next = '0;
          bfly_next  = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        bfly_next = bfly_reg + 7'd1;
        if (bfly_reg == 7'd127) begin
          drain_next = 4'(WB_LAT);
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last drain cycle coincides with the last write of the layer
        if (drain_reg == 4'd1) begin
          if (layer_reg == 3'(NLAYERS - 1)) begin
            state_next = ST_DONE;
          end else begin
            layer_next = layer_reg + 3'd1;
            bfly_next  = '0;
            state_next = ST_RUN;
          end
        end else begin
          drain_next = drain_reg - 4'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_en = (state_reg == ST_RUN);

  // Shifts in every state so a drain always flushes the final writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WB_LAT; i++) begin
        wb_line[i] <= '0;
      end
    end else begin
      for (int i = WB_LAT - 1; i > 0; i--) begin
        wb_line[i] <= wb_line[i-1];
      end
      wb_line[0] <= rd_en ? wb_t'{valid: 1'b1, a: gen_a, b: gen_b} : '0;
    end
  end

  assign bus.busy      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign bus.done      = (state_reg == ST_DONE);
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr_a = rd_en ? gen_a : '0;
  assign bus.rd_addr_b = rd_en ? gen_b : '0;
  assign bus.tw_addr   = rd_en ? gen_tw : '0;
  assign bus.bf_mode   = !rd_en ? BF_IDLE : (inv_reg ? BF_INTT : BF_NTT);
  assign bus.wr_en     = wb_line[WB_LAT-1].valid;
  assign bus.wr_addr_a = wb_line[WB_LAT-1].a;
  assign bus.wr_addr_b = wb_line[WB_LAT-1].b;

endmodule
